// File: rtl/wb_trace_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace_checker_if
//  Description : Writeback trace and golden-entry handshake bundle.
//                master = trace/golden producer, slave = trace checker.
//                Signals:
//                  commit_pc/wen/wnum/wdata : one serialized commit per cycle
//                  gold_valid/gold_ready    : golden-entry handshake
//                  gold_pc/wnum/wdata/last  : golden entry payload
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_trace_checker_if;
    logic [31:0] commit_pc;
    logic [3:0]  commit_wen;
    logic [4:0]  commit_wnum;
    logic [31:0] commit_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_wnum;
    logic [31:0] gold_wdata;
    logic        gold_last;

    modport master (
        output commit_pc, commit_wen, commit_wnum, commit_wdata,
        output gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
        input  gold_ready
    );

    modport slave (
        input  commit_pc, commit_wen, commit_wnum, commit_wdata,
        input  gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
        output gold_ready
    );
endinterface
`default_nettype wire

// File: rtl/wb_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module      : wb_trace_checker
//  Description : Compares the serialized writeback trace, commit by commit,
//                against golden entries buffered through a valid/ready port
//                and latches the first divergence.
//  Ports       : clk, resetn (async active-low)
//                enable        - start checking (sampled in IDLE)
//                trace         - commit stream + golden handshake (slave)
//                err/err_code/err_pc/err_exp_wdata/err_got_wdata - first error
//                pass          - final golden entry matched
//                commit_cnt    - matched commits, saturating
//                gold_level    - golden entries buffered
//  Revision    : 1.0  initial release
// ============================================================================
module wb_trace_checker #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  wire                       clk,
    input  wire                       resetn,
    input  wire                       enable,
    wb_trace_checker_if.slave         trace,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [31:0]               err_pc,
    output logic [31:0]               err_exp_wdata,
    output logic [31:0]               err_got_wdata,
    output logic                      pass,
    output logic [CNT_W-1:0]          commit_cnt,
    output logic [$clog2(DEPTH):0]    gold_level
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_ERROR = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [1:0] c_CODE_PC    = 2'd1;
    localparam logic [1:0] c_CODE_DATA  = 2'd2;
    localparam logic [1:0] c_CODE_UNDER = 2'd3;

    logic [1:0]       r_state, w_state_nxt;
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [4:0]       r_mem_wnum  [DEPTH];
    logic [31:0]      r_mem_wdata [DEPTH];
    logic             r_mem_last  [DEPTH];

    logic             r_err, r_pass;
    logic [1:0]       r_err_code;
    logic [31:0]      r_err_pc, r_err_exp, r_err_got;
    logic [CNT_W-1:0] r_cnt;

    logic             w_empty, w_full, w_push, w_pop;
    logic             w_commit, w_pc_ok, w_data_ok;
    logic [31:0]      w_mask;
    logic [31:0]      w_head_pc, w_head_wdata;
    logic [4:0]       w_head_wnum;
    logic             w_head_last;
    logic             w_err_set, w_pass_set;
    logic [1:0]       w_err_code;

    // ---------------------------------------------------------------- buffer
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign trace.gold_ready = !w_full && ((r_state == c_IDLE) || (r_state == c_RUN));
    assign w_push = trace.gold_valid && trace.gold_ready;

    // Head read uses registered contents only, so a same-cycle push never
    // reaches the comparator.
    assign w_head_pc    = r_mem_pc[r_rd_ptr[AW-1:0]];
    assign w_head_wnum  = r_mem_wnum[r_rd_ptr[AW-1:0]];
    assign w_head_wdata = r_mem_wdata[r_rd_ptr[AW-1:0]];
    assign w_head_last  = r_mem_last[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr[AW-1:0]]    <= trace.gold_pc;
            r_mem_wnum[r_wr_ptr[AW-1:0]]  <= trace.gold_wnum;
            r_mem_wdata[r_wr_ptr[AW-1:0]] <= trace.gold_wdata;
            r_mem_last[r_wr_ptr[AW-1:0]]  <= trace.gold_last;
        end
    end

    // --------------------------------------------------------------- compare
    assign w_commit = |trace.commit_wen;
    assign w_mask   = {{8{trace.commit_wen[3]}}, {8{trace.commit_wen[2]}},
                       {8{trace.commit_wen[1]}}, {8{trace.commit_wen[0]}}};
    assign w_pc_ok   = (trace.commit_pc == w_head_pc);
    assign w_data_ok = (trace.commit_wnum == w_head_wnum) &&
                       ((trace.commit_wdata & w_mask) == (w_head_wdata & w_mask));

    // ------------------------------------------------------ FSM: state reg
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ------------------------------------------------------ FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (enable) w_state_nxt = c_RUN;
            c_RUN: begin
                if (w_commit) begin
                    if (w_empty || !w_pc_ok || !w_data_ok) w_state_nxt = c_ERROR;
                    else if (w_head_last)                  w_state_nxt = c_DONE;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // ------------------------------------------------------ FSM: outputs
    always_comb begin
        w_pop      = 1'b0;
        w_err_set  = 1'b0;
        w_pass_set = 1'b0;
        w_err_code = 2'd0;
        if ((r_state == c_RUN) && w_commit) begin
            if (w_empty) begin
                w_err_set  = 1'b1;
                w_err_code = c_CODE_UNDER;
            end else if (!w_pc_ok) begin
                w_err_set  = 1'b1;
                w_err_code = c_CODE_PC;
            end else if (!w_data_ok) begin
                w_err_set  = 1'b1;
                w_err_code = c_CODE_DATA;
            end else begin
                w_pop      = 1'b1;
                w_pass_set = w_head_last;
            end
        end
    end

    // -------------------------------------------------- pointers and status
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_err_pc   <= 32'd0;
            r_err_exp  <= 32'd0;
            r_err_got  <= 32'd0;
            r_pass     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            end
            if (w_pass_set) r_pass <= 1'b1;
            if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
                r_err_pc   <= trace.commit_pc;
                r_err_exp  <= w_empty ? 32'd0 : w_head_wdata;
                r_err_got  <= trace.commit_wdata & w_mask;
            end
        end
    end

    assign err           = r_err;
    assign err_code      = r_err_code;
    assign err_pc        = r_err_pc;
    assign err_exp_wdata = r_err_exp;
    assign err_got_wdata = r_err_got;
    assign pass          = r_pass;
    assign commit_cnt    = r_cnt;
    assign gold_level    = r_wr_ptr - r_rd_ptr;
endmodule
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_trace_checker
//  Description : Directed self-checking bench for wb_trace_checker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_trace_checker;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam logic [31:0] c_PC0 = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        err, pass;
    logic [1:0]  err_code;
    logic [31:0] err_pc, err_exp_wdata, err_got_wdata;
    logic [CNT_W-1:0] commit_cnt;
    logic [$clog2(DEPTH):0] gold_level;

    int n_checks = 0;
    int n_fail   = 0;

    wb_trace_checker_if tif ();

    wb_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .trace         (tif),
        .err           (err),
        .err_code      (err_code),
        .err_pc        (err_pc),
        .err_exp_wdata (err_exp_wdata),
        .err_got_wdata (err_got_wdata),
        .pass          (pass),
        .commit_cnt    (commit_cnt),
        .gold_level    (gold_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end #1 after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = 1'b0;
        tif.commit_wen = 4'd0;
        tif.gold_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] wnum,
                        input logic [31:0] wdata, input logic last);
        tif.gold_valid = 1'b1;
        tif.gold_pc    = pc;
        tif.gold_wnum  = wnum;
        tif.gold_wdata = wdata;
        tif.gold_last  = last;
        tick();
        tif.gold_valid = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wdata);
        tif.commit_pc    = pc;
        tif.commit_wen   = wen;
        tif.commit_wnum  = wnum;
        tif.commit_wdata = wdata;
        tick();
        tif.commit_wen = 4'd0;
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        tif.commit_pc = '0; tif.commit_wen = '0; tif.commit_wnum = '0; tif.commit_wdata = '0;
        tif.gold_valid = 1'b0; tif.gold_pc = '0; tif.gold_wnum = '0;
        tif.gold_wdata = '0; tif.gold_last = 1'b0;

        // ---------------- reset state
        do_reset();
        chk("rst_err",   {63'd0, err}, 64'd0);
        chk("rst_pass",  {63'd0, pass}, 64'd0);
        chk("rst_cnt",   {32'd0, commit_cnt}, 64'd0);
        chk("rst_level", {59'd0, gold_level}, 64'd0);
        chk("rst_ready", {63'd0, tif.gold_ready}, 64'd1);
        chk("rst_code",  {62'd0, err_code}, 64'd0);

        // ---------------- 1: three matching commits -> pass
        push(c_PC0,     5'd1, 32'h11, 1'b0);
        push(c_PC0 + 4, 5'd2, 32'h22, 1'b0);
        push(c_PC0 + 8, 5'd3, 32'h33, 1'b1);
        chk("t1_level", {59'd0, gold_level}, 64'd3);
        start();
        commit(c_PC0, 4'hF, 5'd1, 32'h11);
        chk("t1_cnt1", {32'd0, commit_cnt}, 64'd1);
        commit(c_PC0 + 4, 4'hF, 5'd2, 32'h22);
        chk("t1_pass_early", {63'd0, pass}, 64'd0);
        commit(c_PC0 + 8, 4'hF, 5'd3, 32'h33);
        chk("t1_cnt3", {32'd0, commit_cnt}, 64'd3);
        chk("t1_pass", {63'd0, pass}, 64'd1);
        chk("t1_err",  {63'd0, err}, 64'd0);
        commit(c_PC0 + 12, 4'hF, 5'd4, 32'h44);
        chk("t1_done_ignore", {32'd0, commit_cnt}, 64'd3);
        chk("t1_done_err",    {63'd0, err}, 64'd0);

        // ---------------- 2: data mismatch on 2nd commit
        do_reset();
        push(c_PC0,     5'd1, 32'h11, 1'b0);
        push(c_PC0 + 4, 5'd2, 32'h22, 1'b0);
        push(c_PC0 + 8, 5'd3, 32'h33, 1'b1);
        start();
        commit(c_PC0, 4'hF, 5'd1, 32'h11);
        commit(c_PC0 + 4, 4'hF, 5'd2, 32'h23);
        chk("t2_err",   {63'd0, err}, 64'd1);
        chk("t2_code",  {62'd0, err_code}, 64'd2);
        chk("t2_exp",   {32'd0, err_exp_wdata}, 64'h22);
        chk("t2_got",   {32'd0, err_got_wdata}, 64'h23);
        chk("t2_pc",    {32'd0, err_pc}, {32'd0, c_PC0 + 32'd4});
        chk("t2_cnt",   {32'd0, commit_cnt}, 64'd1);
        chk("t2_ready", {63'd0, tif.gold_ready}, 64'd0);
        commit(c_PC0 + 8, 4'hF, 5'd7, 32'h99);
        chk("t2_frozen_pc",  {32'd0, err_pc}, {32'd0, c_PC0 + 32'd4});
        chk("t2_frozen_lvl", {59'd0, gold_level}, 64'd2);

        // ---------------- 3: byte-masked compare
        do_reset();
        push(c_PC0, 5'd5, 32'h0000_0012, 1'b0);
        start();
        commit(c_PC0, 4'b0001, 5'd5, 32'hABCD_0012);
        chk("t3_err", {63'd0, err}, 64'd0);
        chk("t3_cnt", {32'd0, commit_cnt}, 64'd1);

        // ---------------- 4: underflow
        do_reset();
        start();
        commit(32'hBFC0_0010, 4'b0011, 5'd6, 32'h1234_5678);
        chk("t4_code", {62'd0, err_code}, 64'd3);
        chk("t4_pc",   {32'd0, err_pc}, 64'hBFC0_0010);
        chk("t4_exp",  {32'd0, err_exp_wdata}, 64'd0);
        chk("t4_got",  {32'd0, err_got_wdata}, 64'h5678);

        // ---------------- 5: full buffer, push refused during pop
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            push(c_PC0 + 32'(4 * i), 5'(i), 32'(i + 1), 1'b0);
        chk("t5_ready", {63'd0, tif.gold_ready}, 64'd0);
        chk("t5_level", {59'd0, gold_level}, 64'd16);
        start();
        tif.gold_valid = 1'b1;
        tif.gold_pc = 32'hDEAD_0000; tif.gold_wnum = 5'd9;
        tif.gold_wdata = 32'h5555_5555; tif.gold_last = 1'b1;
        commit(c_PC0, 4'hF, 5'd0, 32'd1);
        tif.gold_valid = 1'b0;
        chk("t5_level_after", {59'd0, gold_level}, 64'd15);
        chk("t5_cnt",         {32'd0, commit_cnt}, 64'd1);
        chk("t5_ready_after", {63'd0, tif.gold_ready}, 64'd1);
        // Refused entry must not have entered: next head is entry 1.
        commit(c_PC0 + 4, 4'hF, 5'd1, 32'd2);
        chk("t5_cnt2", {32'd0, commit_cnt}, 64'd2);
        chk("t5_err",  {63'd0, err}, 64'd0);

        // ---------------- 6: pc priority, async reset mid-run
        do_reset();
        push(c_PC0, 5'd1, 32'h11, 1'b0);
        push(c_PC0 + 4, 5'd2, 32'h22, 1'b1);
        start();
        commit(c_PC0 + 4, 4'hF, 5'd3, 32'h99);
        chk("t6_code", {62'd0, err_code}, 64'd1);
        resetn = 1'b0;
        #2;
        chk("t6_async_err",   {63'd0, err}, 64'd0);
        chk("t6_async_level", {59'd0, gold_level}, 64'd0);
        chk("t6_async_code",  {62'd0, err_code}, 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        // IDLE after reset: commits are ignored.
        push(c_PC0, 5'd1, 32'h11, 1'b0);
        commit(c_PC0, 4'hF, 5'd1, 32'h11);
        chk("t6_idle_cnt",   {32'd0, commit_cnt}, 64'd0);
        chk("t6_idle_level", {59'd0, gold_level}, 64'd1);
        chk("t6_idle_err",   {63'd0, err}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
